// File: rtl/instruction_loader.sv
// Instruction loader: assembles UART bytes into instruction words and writes them
// to an instruction memory.
//
// Byte stream: a count byte N, then N words of NB_DATA/8 bytes each, LSB first.
// Each completed word produces a one-cycle write strobe at byte address 4*word_cnt.
// Addresses wrap modulo 2^NB_ADDR. Exceeding TIMEOUT idle cycles mid-load drops
// the partial word and enters ERROR.
//
// Ports:
//   clock, reset    single clock, synchronous active-high reset
//   rx_data_i       received byte, qualified by rx_done_i
//   rx_done_i       one-cycle byte strobe
//   clear_i         return from DONE/ERROR to IDLE
//   inst_wr_en_o    one-cycle memory write strobe
//   inst_addr_o     byte address of the write (held between writes)
//   inst_data_o     assembled word (held between writes)
//   busy_o          load in progress (RECV or WRITE)
//   load_done_o     all N words written
//   error_o         inter-byte timeout occurred
module instruction_loader #(
  parameter int unsigned NB_DATA = 32,
  parameter int unsigned NB_ADDR = 10,
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [7:0]         rx_data_i,
  input  logic               rx_done_i,
  input  logic               clear_i,
  output logic               inst_wr_en_o,
  output logic [NB_ADDR-1:0] inst_addr_o,
  output logic [NB_DATA-1:0] inst_data_o,
  output logic               busy_o,
  output logic               load_done_o,
  output logic               error_o
);

  localparam int unsigned NbBytes  = NB_DATA / 8;
  localparam int unsigned ByteCntW = (NbBytes > 1) ? $clog2(NbBytes) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StRecv,
    StWrite,
    StDone,
    StError
  } state_e;

  state_e                state_q;
  logic [7:0]            n_q;
  logic [7:0]            word_cnt_q;
  logic [ByteCntW-1:0]   byte_cnt_q;
  logic [NB_DATA-1:0]    word_q;
  logic [31:0]           timeout_q;
  logic                  wr_en_q;
  logic [NB_ADDR-1:0]    addr_q;
  logic [NB_DATA-1:0]    data_q;

  logic [NB_DATA-1:0]    word_with_byte;
  logic                  last_byte;
  logic                  last_word;
  logic                  timed_out;
  logic [NB_ADDR-1:0]    addr_cur;
  logic [NB_ADDR-1:0]    addr_nxt;

  // Current word with the incoming byte dropped into lane byte_cnt.
  always_comb begin
    word_with_byte = word_q;
    word_with_byte[8*byte_cnt_q +: 8] = rx_data_i;
  end

  assign last_byte = (byte_cnt_q == ByteCntW'(NbBytes - 1));
  assign last_word = (({1'b0, word_cnt_q} + 9'd1) == {1'b0, n_q});
  assign timed_out = (timeout_q >= (TIMEOUT - 1));
  assign addr_cur  = NB_ADDR'({word_cnt_q, 2'b00});
  assign addr_nxt  = NB_ADDR'({word_cnt_q + 8'd1, 2'b00});

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= StIdle;
      n_q        <= '0;
      word_cnt_q <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
      timeout_q  <= '0;
      wr_en_q    <= 1'b0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      wr_en_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (rx_done_i) begin
            n_q        <= rx_data_i;
            word_cnt_q <= '0;
            byte_cnt_q <= '0;
            word_q     <= '0;
            timeout_q  <= '0;
            state_q    <= (rx_data_i == 8'd0) ? StDone : StRecv;
          end
        end

        StRecv: begin
          if (rx_done_i) begin
            timeout_q <= '0;
            word_q    <= word_with_byte;
            if (last_byte) begin
              // Stage the write now so the strobe lands on the very next edge.
              byte_cnt_q <= '0;
              data_q     <= word_with_byte;
              addr_q     <= addr_cur;
              wr_en_q    <= 1'b1;
              state_q    <= StWrite;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
            end
          end else if (timed_out) begin
            state_q <= StError;
          end else begin
            timeout_q <= timeout_q + 32'd1;
          end
        end

        StWrite: begin
          word_cnt_q <= word_cnt_q + 8'd1;
          if (last_word) begin
            state_q <= StDone;
          end else if (rx_done_i) begin
            // Byte arriving during the write is byte 0 of the next word.
            timeout_q <= '0;
            word_q    <= word_with_byte;
            if (last_byte) begin
              // Single-byte words: this byte completes the next word already.
              data_q  <= word_with_byte;
              addr_q  <= addr_nxt;
              wr_en_q <= 1'b1;
              state_q <= StWrite;
            end else begin
              byte_cnt_q <= byte_cnt_q + 1'b1;
              state_q    <= StRecv;
            end
          end else begin
            timeout_q <= timeout_q + 32'd1;
            state_q   <= StRecv;
          end
        end

        StDone, StError: begin
          if (clear_i) begin
            state_q <= StIdle;
          end
        end

        default: state_q <= StIdle;
      endcase
    end
  end

  assign inst_wr_en_o = wr_en_q;
  assign inst_addr_o  = addr_q;
  assign inst_data_o  = data_q;
  assign busy_o       = (state_q == StRecv) || (state_q == StWrite);
  assign load_done_o  = (state_q == StDone);
  assign error_o      = (state_q == StError);

endmodule
